fb_mem_responder: RTL
=====================

Name: fb_mem_responder

Overview:
- Memory-side responder for the fill engine's wide block interface (read_enable / write_enable / address / read_data / write_data).
- Each request moves one 64-pixel block (1536 bits) between the fill engine and a narrow single-port pixel SRAM, one 24-bit word per beat.
- Write requests are serialized out to the SRAM. Read requests are gathered from the SRAM and returned as one wide word with a completion pulse.
- Sits between fill_wrapper and the frame-buffer SRAM model/pads.

Parameters:
ADDR_SIZE_BITS, 24, width of block and SRAM word address
WORD_SIZE_BYTES, 3, bytes per pixel word (SRAM data width = WORD_SIZE_BYTES*8)
DATA_SIZE_WORDS, 64, pixel words per block transfer

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
read_enable  input  1  block read request, sampled only in IDLE
write_enable  input  1  block write request, sampled only in IDLE
address  input  ADDR_SIZE_BITS  base word address of block
write_data  input  WORD_SIZE_BYTES*DATA_SIZE_WORDS*8  block to store; word k = bits [24k+23:24k]
read_data  output  WORD_SIZE_BYTES*DATA_SIZE_WORDS*8  returned block, same packing
busy  output  1  high whenever not IDLE
done  output  1  one-cycle pulse at completion of any transfer
req_conflict  output  1  one-cycle pulse when read_enable and write_enable are both high in IDLE
sram_addr  output  ADDR_SIZE_BITS  SRAM word address
sram_wdata  output  WORD_SIZE_BYTES*8  SRAM write data
sram_we  output  1  SRAM write strobe
sram_re  output  1  SRAM read strobe
sram_rdata  input  WORD_SIZE_BYTES*8  SRAM read data, valid exactly 1 cycle after sram_re

Behaviour:
- Reset (async, n_rst=0): state IDLE. All outputs 0, including read_data. Beat counter, captured address, write buffer and read buffer all cleared.
- States: IDLE, WRITE, READ, READ_LAST, DONE.
- IDLE:
  - write_enable=1: capture address and write_data; go to WRITE.
  - read_enable=1 only: capture address; go to READ.
  - Both high: write wins; req_conflict pulses in the same cycle as capture (registered, visible the cycle after the sampling edge).
- Requests seen outside IDLE are ignored, not queued. Requesters must wait for busy=0.
- WRITE:
  - Beat counter k runs 0..DATA_SIZE_WORDS-1.
  - Each cycle: sram_we=1, sram_addr=base+k, sram_wdata=word k.
  - After beat 63, go to DONE.
- READ:
  - Each cycle: sram_re=1, sram_addr=base+k, k runs 0..63.
  - Data returned one cycle later is stored into word (k-1) of the read buffer.
  - After beat 63, go to READ_LAST.
- READ_LAST: no strobe. Capture word 63, load read_data from the buffer, go to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- read_data changes only on READ_LAST→DONE and otherwise holds its last value; write transfers never alter it.
- Latency, with the request sampled at edge 0:
  - Write: strobes in cycles 1..64, done in cycle 65.
  - Read: strobes in cycles 1..64, done in cycle 66, read_data valid from cycle 66 onward.
  - Back-to-back: the next request can be sampled at the first IDLE cycle after done.
- Address arithmetic: base+k modulo 2^ADDR_SIZE_BITS. The block wraps from 0xFFFFFF to 0x000000.
- sram_we and sram_re are never high simultaneously; both are 0 in IDLE, READ_LAST and DONE.
- sram_addr and sram_wdata are 0 whenever no strobe is asserted.
- Reset mid-transfer: abort immediately with no done pulse; read_data clears to 0; SRAM strobes drop asynchronously.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, busy=0, no strobes.
- Write at address 0x000100, word k = 0x0A0000+k -> 64 sram_we beats at 0x100..0x13F with matching data; done in cycle 65; busy high cycles 1..65.
- Read at address 0x000100 after the write, SRAM model with 1-cycle latency -> 64 sram_re beats; done in cycle 66; read_data word k = 0x0A0000+k.
- Write at address 0xFFFFE0 -> addresses 0xFFFFE0..0xFFFFFF then 0x000000..0x00001F, no gaps.
- read_enable=1 and write_enable=1 together, then a read_enable pulse mid-transfer -> write performed, req_conflict pulses once, the mid-transfer read is ignored (no second transfer).
- n_rst low at beat 30 of a read -> strobes drop at once; no done; read_data=0; a new read after reset completes correctly.

Source files
------------

// File: rtl/fb_mem_responder.sv
// Block-wide memory responder: serializes 64-word block writes to a narrow SRAM and
// gathers 64-word block reads back into one wide word, with a done pulse per transfer.
module fb_mem_responder #(
    parameter int unsigned ADDR_SIZE_BITS  = 24,
    parameter int unsigned WORD_SIZE_BYTES = 3,
    parameter int unsigned DATA_SIZE_WORDS = 64
) (
    input  logic                                        clk,
    input  logic                                        n_rst,
    input  logic                                        read_enable,
    input  logic                                        write_enable,
    input  logic [ADDR_SIZE_BITS-1:0]                   address,
    input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] write_data,
    output logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        req_conflict,
    output logic [ADDR_SIZE_BITS-1:0]                   sram_addr,
    output logic [WORD_SIZE_BYTES*8-1:0]                sram_wdata,
    output logic                                        sram_we,
    output logic                                        sram_re,
    input  logic [WORD_SIZE_BYTES*8-1:0]                sram_rdata
);

    localparam int unsigned WordW  = WORD_SIZE_BYTES * 8;
    localparam int unsigned BlockW = WordW * DATA_SIZE_WORDS;
    localparam int unsigned CntW   = (DATA_SIZE_WORDS > 1) ? $clog2(DATA_SIZE_WORDS) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(DATA_SIZE_WORDS - 1);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StReadLast, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       beat_q, beat_d;
    logic [CntW-1:0]       prev_beat;
    logic [ADDR_SIZE_BITS-1:0] base_q;
    logic [BlockW-1:0]     wbuf_q;
    // The last word bypasses the gather buffer and lands straight in read_data.
    logic [BlockW-WordW-1:0] rbuf_q;
    logic [BlockW-1:0]     rdata_q;
    logic                  conflict_q, conflict_d;

    assign prev_beat = beat_q - 1'b1;

    always_comb begin
        state_d    = state_q;
        beat_d     = '0;
        conflict_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                conflict_d = read_enable && write_enable;
                if (write_enable) begin
                    state_d = StWrite;
                end else if (read_enable) begin
                    state_d = StRead;
                end
            end
            StWrite: begin
                if (beat_q == LastBeat) begin
                    state_d = StDone;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            StRead: begin
                if (beat_q == LastBeat) begin
                    state_d = StReadLast;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            StReadLast: state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            base_q     <= '0;
            wbuf_q     <= '0;
            rbuf_q     <= '0;
            rdata_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            conflict_q <= conflict_d;
            if (state_q == StIdle) begin
                if (write_enable) begin
                    base_q <= address;
                    wbuf_q <= write_data;
                end else if (read_enable) begin
                    base_q <= address;
                end
            end
            // SRAM data trails the strobe by one cycle, so it belongs to the previous beat.
            if (state_q == StRead && beat_q != '0) begin
                rbuf_q[prev_beat*WordW +: WordW] <= sram_rdata;
            end
            if (state_q == StReadLast) begin
                rdata_q <= {sram_rdata, rbuf_q};
            end
        end
    end

    always_comb begin
        busy         = (state_q != StIdle);
        done         = (state_q == StDone);
        req_conflict = conflict_q;
        read_data    = rdata_q;
        sram_we      = (state_q == StWrite);
        sram_re      = (state_q == StRead);
        sram_addr    = '0;
        sram_wdata   = '0;
        if (sram_we || sram_re) begin
            sram_addr = base_q + ADDR_SIZE_BITS'(beat_q);
        end
        if (sram_we) begin
            sram_wdata = wbuf_q[beat_q*WordW +: WordW];
        end
    end

endmodule
